// File: rtl/dcache_2way_if.sv
// dcache_2way_if: bus bundle between the processor datapath, the data cache
// and main memory.
//   cpu side : cpu_req, cpu_we, fADDR, cpu_wdata (to cache)
//              cpu_rdata, cpu_ready, cpu_hit     (from cache)
//   mem side : mem_req, mem_we, mem_addr, mem_wdata (from cache)
//              mem_rdata, mem_ack                   (to cache)
// Modports: slave  = the cache's view
//           master = the environment's view (processor + memory)
interface dcache_2way_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] fADDR;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_hit;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  cpu_req, cpu_we, fADDR, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, fADDR, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_2way.sv
// dcache_2way: 2-way set-associative data cache, 4 sets, one word per line,
// write-back / write-allocate, 1-bit LRU per set.
// Ports:
//   clock - single rising-edge clock
//   reset - asynchronous, active-high; clears V/D/LRU bits, outputs and FSM
//           (tag and data arrays keep their contents)
//   bus   - dcache_2way_if.slave: cpu request/response and memory req/ack
// Flow: IDLE latches the request, COMPARE looks up both ways. A miss picks a
// victim, optionally writes it back (WRITEBACK), fetches the line
// (ALLOCATE) and returns to COMPARE, which then always hits and performs
// the access. DONE pulses cpu_ready for one cycle.
module dcache_2way #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int IDX_W  = 2
) (
    input  logic clock,
    input  logic reset,
    dcache_2way_if.slave bus
);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int SETS  = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        DONE
    } state_t;

    state_t state_reg, state_next;

    // latched request
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              we_reg, we_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              miss_reg, miss_next;
    logic              victim_reg, victim_next;

    // registered outputs
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              hit_out_reg, hit_out_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;

    // line state bits, indexed [way][set]
    logic [1:0][SETS-1:0] valid_reg, valid_next;
    logic [1:0][SETS-1:0] dirty_reg, dirty_next;
    // lru_reg[set] names the way to evict next
    logic [SETS-1:0]      lru_reg, lru_next;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    assign idx = addr_reg[IDX_W-1:0];
    assign tag = addr_reg[ADDR_W-1:IDX_W];

    logic [TAG_W-1:0]  way_tag  [2];
    logic [DATA_W-1:0] way_data [2];
    logic [1:0]        way_hit;
    logic [1:0]        tag_we;
    logic [1:0]        data_we;
    logic [DATA_W-1:0] data_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            logic [TAG_W-1:0]  tag_arr  [SETS];
            logic [DATA_W-1:0] data_arr [SETS];

            // Arrays are never reset; only the V bit says whether they matter.
            always_ff @(posedge clock) begin
                if (tag_we[gi]) begin
                    tag_arr[idx] <= tag;
                end
                if (data_we[gi]) begin
                    data_arr[idx] <= data_in;
                end
            end

            assign way_tag[gi]  = tag_arr[idx];
            assign way_data[gi] = data_arr[idx];
            assign way_hit[gi]  = valid_reg[gi][idx] && (way_tag[gi] == tag);
        end
    endgenerate

    logic hit_way;
    logic victim_sel;
    assign hit_way = way_hit[1];
    // Fill invalid ways first (way0 before way1), otherwise evict the LRU way.
    assign victim_sel = !valid_reg[0][idx] ? 1'b0 :
                        (!valid_reg[1][idx] ? 1'b1 : lru_reg[idx]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            we_reg        <= 1'b0;
            wdata_reg     <= '0;
            miss_reg      <= 1'b0;
            victim_reg    <= 1'b0;
            rdata_reg     <= '0;
            hit_out_reg   <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            valid_reg     <= '0;
            dirty_reg     <= '0;
            lru_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            we_reg        <= we_next;
            wdata_reg     <= wdata_next;
            miss_reg      <= miss_next;
            victim_reg    <= victim_next;
            rdata_reg     <= rdata_next;
            hit_out_reg   <= hit_out_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            valid_reg     <= valid_next;
            dirty_reg     <= dirty_next;
            lru_reg       <= lru_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        we_next        = we_reg;
        wdata_next     = wdata_reg;
        miss_next      = miss_reg;
        victim_next    = victim_reg;
        rdata_next     = rdata_reg;
        hit_out_next   = hit_out_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        valid_next     = valid_reg;
        dirty_next     = dirty_reg;
        lru_next       = lru_reg;
        tag_we         = 2'b00;
        data_we        = 2'b00;
        data_in        = wdata_reg;

        case (state_reg)
            IDLE: begin
                if (bus.cpu_req) begin
                    addr_next  = bus.fADDR;
                    we_next    = bus.cpu_we;
                    wdata_next = bus.cpu_wdata;
                    miss_next  = 1'b0;
                    state_next = COMPARE;
                end
            end

            COMPARE: begin
                if (|way_hit) begin
                    if (we_reg) begin
                        data_we[hit_way]         = 1'b1;
                        data_in                  = wdata_reg;
                        dirty_next[hit_way][idx] = 1'b1;
                    end else begin
                        rdata_next = way_data[hit_way];
                    end
                    lru_next[idx] = ~hit_way;
                    hit_out_next  = ~miss_reg;
                    state_next    = DONE;
                end else begin
                    miss_next    = 1'b1;
                    victim_next  = victim_sel;
                    mem_req_next = 1'b1;
                    if (valid_reg[victim_sel][idx] && dirty_reg[victim_sel][idx]) begin
                        mem_addr_next  = {way_tag[victim_sel], idx};
                        mem_wdata_next = way_data[victim_sel];
                        mem_we_next    = 1'b1;
                        state_next     = WRITEBACK;
                    end else begin
                        mem_addr_next = addr_reg;
                        mem_we_next   = 1'b0;
                        state_next    = ALLOCATE;
                    end
                end
            end

            WRITEBACK: begin
                if (mem_req_reg && bus.mem_ack) begin
                    dirty_next[victim_reg][idx] = 1'b0;
                    // The fetch is a separate transaction: mem_req drops for
                    // one cycle and ALLOCATE re-raises it with the new address.
                    mem_req_next  = 1'b0;
                    mem_addr_next = addr_reg;
                    mem_we_next   = 1'b0;
                    state_next    = ALLOCATE;
                end
            end

            ALLOCATE: begin
                if (!mem_req_reg) begin
                    mem_req_next = 1'b1;
                end else if (bus.mem_ack) begin
                    data_we[victim_reg]         = 1'b1;
                    tag_we[victim_reg]          = 1'b1;
                    data_in                     = bus.mem_rdata;
                    valid_next[victim_reg][idx] = 1'b1;
                    dirty_next[victim_reg][idx] = 1'b0;
                    mem_req_next                = 1'b0;
                    state_next                  = COMPARE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.cpu_rdata = rdata_reg;
    assign bus.cpu_ready = (state_reg == DONE);
    assign bus.cpu_hit   = hit_out_reg;
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
endmodule

// File: tb/tb_dcache_2way.sv
// tb_dcache_2way: directed bench for dcache_2way. A memory model answers
// mem_req after mem_wait cycles and logs every acknowledged transaction.
// Each access pushes its expected result onto a scoreboard queue and pops
// it when cpu_ready arrives; memory traffic is compared against a queue of
// expected transactions.
module tb_dcache_2way;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dcache_2way_if #(.DATA_W(16), .ADDR_W(6)) bus ();

    dcache_2way #(.DATA_W(16), .ADDR_W(6), .IDX_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int mem_wait = 2;

    typedef struct packed {
        logic        we;
        logic [5:0]  addr;
        logic [15:0] data;
    } mem_t;

    typedef struct {
        logic        we;
        logic        hit;
        logic [15:0] rdata;
        int          lat;
    } exp_t;

    mem_t mem_log[$];
    mem_t mem_exp[$];
    exp_t sb[$];
    logic [15:0] mem [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_mem(input logic we, input logic [5:0] a, input logic [15:0] d);
        mem_t e;
        e.we   = we;
        e.addr = a;
        e.data = we ? d : 16'h0;
        mem_exp.push_back(e);
    endtask

    // Memory model: acknowledges after mem_wait cycles of mem_req.
    initial begin
        int wcnt;
        mem_t e;
        wcnt = 0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        mem[5] = 16'h1234;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0;
        forever begin
            @(negedge clock);
            bus.mem_ack = 1'b0;
            if (bus.mem_req && !reset) begin
                if (wcnt >= mem_wait) begin
                    bus.mem_ack = 1'b1;
                    e.we   = bus.mem_we;
                    e.addr = bus.mem_addr;
                    e.data = bus.mem_we ? bus.mem_wdata : 16'h0;
                    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = mem[bus.mem_addr];
                    mem_log.push_back(e);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic access(input string tag, input logic we, input logic [5:0] a,
                          input logic [15:0] wd, input logic exp_hit,
                          input logic [15:0] exp_rd, input int exp_lat);
        exp_t e;
        int n;
        int cnt;
        e.we = we; e.hit = exp_hit; e.rdata = exp_rd; e.lat = exp_lat;
        sb.push_back(e);
        @(negedge clock);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.fADDR     = a;
        bus.cpu_wdata = wd;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!bus.cpu_ready && n < 100);
        bus.cpu_req = 1'b0;
        e = sb.pop_front();
        chk($sformatf("%s_ready", tag), 32'(bus.cpu_ready), 32'd1);
        chk($sformatf("%s_latency", tag), 32'(n), 32'(e.lat));
        chk($sformatf("%s_hit", tag), 32'(bus.cpu_hit), 32'(e.hit));
        if (!e.we) chk($sformatf("%s_rdata", tag), 32'(bus.cpu_rdata), 32'(e.rdata));
        cnt = (mem_log.size() < mem_exp.size()) ? mem_log.size() : mem_exp.size();
        chk($sformatf("%s_memcount", tag), 32'(mem_log.size()), 32'(mem_exp.size()));
        for (int i = 0; i < cnt; i++)
            chk($sformatf("%s_memtxn%0d", tag, i), 32'(mem_log[i]), 32'(mem_exp[i]));
        $display("access %s we=%0d addr=%02h wdata=%04h -> rdata=%04h hit=%0d cycles=%0d memtxns=%0d",
                 tag, we, a, wd, bus.cpu_rdata, bus.cpu_hit, n, mem_log.size());
        mem_log.delete();
        mem_exp.delete();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_hit;
        int lat_clean;
        int lat_dirty;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.fADDR     = 6'h0;
        bus.cpu_wdata = 16'h0;
        lat_hit   = 2;
        lat_clean = 4 + mem_wait;
        lat_dirty = 6 + 2 * mem_wait;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_cpu_hit",   32'(bus.cpu_hit),   32'd0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst_mem_req",   32'(bus.mem_req),   32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);

        // cold load, then hits and a store hit
        expect_mem(1'b0, 6'h05, 16'h0);
        access("ld05_miss", 1'b0, 6'h05, 16'h0, 1'b0, 16'h1234, lat_clean);
        access("ld05_hit",  1'b0, 6'h05, 16'h0, 1'b1, 16'h1234, lat_hit);
        access("st05_hit",  1'b1, 6'h05, 16'hBEEF, 1'b1, 16'h0, lat_hit);
        access("ld05_beef", 1'b0, 6'h05, 16'h0, 1'b1, 16'hBEEF, lat_hit);

        // set conflict on index 1: way1 (0x09) becomes LRU and is evicted clean
        expect_mem(1'b0, 6'h09, 16'h0);
        access("ld09_miss", 1'b0, 6'h09, 16'h0, 1'b0, 16'h1009, lat_clean);
        access("ld05_lru",  1'b0, 6'h05, 16'h0, 1'b1, 16'hBEEF, lat_hit);
        expect_mem(1'b0, 6'h0D, 16'h0);
        access("ld0D_evict", 1'b0, 6'h0D, 16'h0, 1'b0, 16'h100D, lat_clean);
        access("ld05_kept", 1'b0, 6'h05, 16'h0, 1'b1, 16'hBEEF, lat_hit);

        // dirty eviction on index 2
        expect_mem(1'b0, 6'h02, 16'h0);
        access("st02_miss", 1'b1, 6'h02, 16'hAAAA, 1'b0, 16'h0, lat_clean);
        expect_mem(1'b0, 6'h06, 16'h0);
        access("st06_miss", 1'b1, 6'h06, 16'h5555, 1'b0, 16'h0, lat_clean);
        expect_mem(1'b1, 6'h02, 16'hAAAA);
        expect_mem(1'b0, 6'h0A, 16'h0);
        access("ld0A_wb", 1'b0, 6'h0A, 16'h0, 1'b0, 16'h100A, lat_dirty);
        expect_mem(1'b1, 6'h06, 16'h5555);
        expect_mem(1'b0, 6'h02, 16'h0);
        access("ld02_refetch", 1'b0, 6'h02, 16'h0, 1'b0, 16'hAAAA, lat_dirty);

        // write-miss allocate on index 3, later written back
        expect_mem(1'b0, 6'h3F, 16'h0);
        access("st3F_alloc", 1'b1, 6'h3F, 16'h7777, 1'b0, 16'h0, lat_clean);
        expect_mem(1'b0, 6'h33, 16'h0);
        access("ld33_fill", 1'b0, 6'h33, 16'h0, 1'b0, 16'h1033, lat_clean);
        expect_mem(1'b1, 6'h3F, 16'h7777);
        expect_mem(1'b0, 6'h37, 16'h0);
        access("ld37_wb3F", 1'b0, 6'h37, 16'h0, 1'b0, 16'h1037, lat_dirty);

        // reset while a fetch is outstanding
        mem_wait = 6;
        @(negedge clock);
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b0;
        bus.fADDR   = 6'h13;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("abort_req_before",  32'(bus.mem_req),  32'd1);
        chk("abort_addr_before", 32'(bus.mem_addr), 32'h13);
        chk("abort_we_before",   32'(bus.mem_we),   32'd0);
        reset = 1'b1;
        #1;
        chk("abort_req_dropped", 32'(bus.mem_req),  32'd0);
        chk("abort_addr_clear",  32'(bus.mem_addr), 32'd0);
        bus.cpu_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        mem_wait = 2;
        repeat (3) @(posedge clock);
        #1;
        chk("abort_idle_req",   32'(bus.mem_req),   32'd0);
        chk("abort_idle_ready", 32'(bus.cpu_ready), 32'd0);
        chk("abort_no_txn",     32'(mem_log.size()), 32'd0);
        mem_log.delete();

        expect_mem(1'b0, 6'h13, 16'h0);
        access("ld13_after_rst", 1'b0, 6'h13, 16'h0, 1'b0, 16'h1013, lat_clean);
        // dirty 0xBEEF line was discarded by reset, memory still holds 0x1234
        expect_mem(1'b0, 6'h05, 16'h0);
        access("ld05_after_rst", 1'b0, 6'h05, 16'h0, 1'b0, 16'h1234, lat_clean);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
